mips_multicycle_core: RTL and testbench



---
 rtl/mips_mc_pkg.sv | 18 +
 rtl/mc_regfile.sv | 21 ++
 rtl/mips_multicycle_core.sv | 94 +++++++++
 tb/tb_mips_multicycle_core.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcode/funct constants, ALU control codes and FSM states shared by the multicycle core
package mips_mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111;
  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, ADDIWB, BRANCH, JUMP, HALT
  } state_t;
  // returns {legal, alu_ctl}; an unsupported funct comes back with legal = 0
  function automatic logic [3:0] funct_ctl(input logic [5:0] fn);
    return fn == FN_ADD ? {1'b1, ALU_ADD} :
           fn == FN_SUB ? {1'b1, ALU_SUB} :
           fn == FN_AND ? {1'b1, ALU_AND} :
           fn == FN_OR  ? {1'b1, ALU_OR}  :
           fn == FN_SLT ? {1'b1, ALU_SLT} : 4'b0000;
  endfunction
endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREGS x 32 register file, two asynchronous read ports, one write port, r0 reads zero
module mc_regfile #(
  parameter int NREGS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [31:0]              wd,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  output logic [31:0]              rd1,
  output logic [31:0]              rd2
);
  logic [31:0] regs [NREGS];
  always_ff @(posedge clock or negedge reset)
    if (!reset) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (we && wa != '0) regs[wa] <= wd;
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: FSM-sequenced MIPS subset with one shared ALU and one req/ready memory port
module mips_multicycle_core import mips_mc_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 16,
  parameter int          NREGS    = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              halted,
  output logic [31:0]       pc_dbg
);
  localparam int RW = $clog2(NREGS);
  state_t state, nxt;
  logic [31:0] pc, ir, a, b, alu_out, mdr, rd1, rd2, alu_x, alu_y, alu_res, se, rf_wd;
  logic [5:0] op;
  logic [3:0] fctl;
  logic [2:0] alu_ctl;
  logic rf_we;
  logic [RW-1:0] rf_wa;
  assign op = ir[31:26];
  assign se = {{16{ir[15]}}, ir[15:0]};
  assign fctl = funct_ctl(ir[5:0]);
  assign pc_dbg = pc;
  mc_regfile #(.NREGS(NREGS)) u_rf (
    .clock(clock), .reset(reset), .we(rf_we), .wa(rf_wa), .wd(rf_wd),
    .ra1(ir[21 +: RW]), .ra2(ir[16 +: RW]), .rd1(rd1), .rd2(rd2)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= RST;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      RST:    nxt = FETCH;
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: nxt = op == OP_RTYPE ? EXEC :
                    (op == OP_LW || op == OP_SW || op == OP_ADDI) ? MEMADR :
                    (op == OP_BEQ || op == OP_BNE) ? BRANCH :
                    op == OP_J ? JUMP : HALT;
      EXEC:   nxt = fctl[3] ? ALUWB : HALT;
      MEMADR: nxt = op == OP_ADDI ? ADDIWB : alu_res[1:0] != 2'b00 ? HALT : op == OP_LW ? MEMRD : MEMWR;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      ALUWB, MEMWB, ADDIWB, BRANCH, JUMP: nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  // the single ALU computes PC+4 in FETCH and the branch target in DECODE
  always_comb begin
    mem_req   = state inside {FETCH, MEMRD, MEMWR};
    mem_we    = state == MEMWR;
    mem_addr  = state == FETCH ? pc[ADDR_W-1:0] : alu_out[ADDR_W-1:0];
    mem_wdata = b;
    halted    = state == HALT;
    alu_x     = (state == FETCH || state == DECODE) ? pc : a;
    alu_y     = state == FETCH ? 32'd4 : state == DECODE ? se << 2 : state == EXEC ? b : se;
    alu_ctl   = state == EXEC ? fctl[2:0] : ALU_ADD;
    rf_we     = state inside {ALUWB, MEMWB, ADDIWB};
    rf_wa     = state == ALUWB ? ir[11 +: RW] : ir[16 +: RW];
    rf_wd     = state == MEMWB ? mdr : alu_out;
  end
  assign alu_res = alu_ctl == ALU_AND ? alu_x & alu_y :
                   alu_ctl == ALU_OR  ? alu_x | alu_y :
                   alu_ctl == ALU_SUB ? alu_x - alu_y :
                   alu_ctl == ALU_SLT ? {31'b0, $signed(alu_x) < $signed(alu_y)} : alu_x + alu_y;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (state == FETCH && mem_ready) begin
        ir <= mem_rdata;
        pc <= alu_res;
      end
      if (state == DECODE) begin
        a <= rd1;
        b <= rd2;
      end
      if (state inside {DECODE, EXEC, MEMADR}) alu_out <= alu_res;
      if (state == MEMRD && mem_ready) mdr <= mem_rdata;
      if (state == BRANCH && ((a == b) ^ (op == OP_BNE))) pc <= alu_out;
      if (state == JUMP) pc <= {pc[31:28], ir[25:0], 2'b00};
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: scoreboard bench; an instruction-level model predicts every memory
// transaction (kind, address, store data, completion cycle) and the halt cycle/PC of each program.
module tb_mips_multicycle_core;
  typedef struct {bit we; logic [31:0] addr; logic [31:0] data; int cyc;} txn_t;
  logic clock = 0, reset = 0, mem_ready = 0;
  logic [31:0] mem_rdata = 0;
  logic mem_req, mem_we, halted;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, pc_dbg;
  logic [31:0] img [1024], mem [1024], rmem [1024];
  int wq [4096];
  txn_t exp_q [$];
  int checks = 0, errors = 0, cyc = 0, ridx = 0, stall = 0, exp_halt = 0;
  bit busy = 0;
  logic [31:0] exp_pc;

  mips_multicycle_core dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .halted(halted), .pc_dbg(pc_dbg)
  );

  always #5 clock = ~clock;
  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] er(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] ej(input logic [25:0] t);
    return {6'h02, t};
  endfunction
  function automatic int rr();
    return $urandom_range(0, 31);
  endfunction
  function automatic logic [5:0] fn_pick(input int k);
    return k == 0 ? 6'h20 : k == 1 ? 6'h22 : k == 2 ? 6'h24 : k == 3 ? 6'h25 : 6'h2A;
  endfunction

  // memory responder: each transaction consumes a preplanned stall count from wq
  initial forever begin
    @(negedge clock);
    if (!reset || !mem_req) begin
      busy = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end else begin
      if (!busy) begin
        busy = 1;
        stall = ridx < 4096 ? wq[ridx] : 0;
        ridx++;
      end
      if (stall == 0) begin
        mem_ready = 1;
        busy = 0;
        mem_rdata = mem[mem_addr[11:2]];
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      end else begin
        mem_ready = 0;
        stall--;
      end
    end
  end

  // monitor: stability during stalls, and every completed transaction against the scoreboard
  initial begin
    txn_t e;
    bit sp;
    logic [15:0] sa;
    logic swe;
    logic [31:0] sd;
    sp = 0;
    forever begin
      @(negedge clock);
      #2;
      if (reset && sp && mem_req) begin
        chk("stall_addr", 32'(mem_addr), 32'(sa));
        chk("stall_we", 32'(mem_we), 32'(swe));
        chk("stall_wdata", mem_wdata, sd);
      end
      if (reset && mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_txn: got we=%b addr %h at cycle %0d, expected no transaction", mem_we, mem_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("txn_we", 32'(mem_we), 32'(e.we));
          chk("txn_addr", 32'(mem_addr), 32'(e.addr[15:0]));
          if (e.we) chk("txn_wdata", mem_wdata, e.data);
          chk("txn_cycle", cyc, e.cyc);
        end
      end
      sp = reset && mem_req && !mem_ready;
      sa = mem_addr;
      swe = mem_we;
      sd = mem_wdata;
    end
  end

  // instruction-level reference: architectural effects plus the documented cycle costs
  task automatic run_iss();
    logic [31:0] r [32];
    logic [31:0] pc, ins, a, b, se, ad, res;
    int t, k;
    bit done;
    for (int i = 0; i < 32; i++) r[i] = 0;
    pc = 0; t = 1; k = 0; done = 0;
    for (int s = 0; s < 3000 && !done; s++) begin
      ins = rmem[pc[11:2]];
      t += wq[k]; k++;
      exp_q.push_back('{0, pc, 32'h0, t});
      pc += 4;
      a = r[ins[25:21]]; b = r[ins[20:16]];
      se = {{16{ins[15]}}, ins[15:0]};
      ad = a + se;
      case (ins[31:26])
        6'h00: begin
          res = 0;
          case (ins[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
            default: done = 1;
          endcase
          if (done) exp_halt = t + 3;
          else begin r[ins[15:11]] = res; t += 4; end
        end
        6'h08: begin r[ins[20:16]] = ad; t += 4; end
        6'h23, 6'h2B: begin
          if (ad[1:0] != 0) begin done = 1; exp_halt = t + 3; end
          else begin
            t += 3 + wq[k]; k++;
            if (ins[31:26] == 6'h23) begin
              exp_q.push_back('{0, ad, 32'h0, t});
              r[ins[20:16]] = rmem[ad[11:2]];
              t += 2;
            end else begin
              exp_q.push_back('{1, ad, b, t});
              rmem[ad[11:2]] = b;
              t += 1;
            end
          end
        end
        6'h04: begin if (a == b) pc = pc + (se << 2); t += 3; end
        6'h05: begin if (a != b) pc = pc + (se << 2); t += 3; end
        6'h02: begin pc = {pc[31:28], ins[25:0], 2'b00}; t += 3; end
        default: begin done = 1; exp_halt = t + 2; end
      endcase
      r[0] = 0;
    end
    exp_pc = pc;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = i >= 128 ? $urandom : 32'h0;
  endtask

  task automatic build_a();
    clear_img();
    img[0] = ei(6'h08, 0, 1, 16'd5);
    img[1] = ei(6'h08, 0, 2, 16'd7);
    img[2] = er(1, 2, 3, 6'h20);
    img[3] = ei(6'h2B, 0, 3, 16'd8);
    img[4] = ei(6'h23, 0, 4, 16'd8);
    img[5] = ei(6'h2B, 0, 4, 16'd12);
    img[6] = 32'hFC00_0000;
  endtask

  task automatic build_b();
    clear_img();
    img[0]  = ei(6'h08, 0, 1, 16'd5);
    img[1]  = ei(6'h08, 0, 0, 16'd9);
    img[2]  = er(0, 0, 5, 6'h20);
    img[3]  = ei(6'h2B, 0, 5, 16'h0080);
    img[4]  = ei(6'h04, 1, 1, 16'd2);
    img[5]  = 32'hFC00_0000;
    img[6]  = 32'hFC00_0000;
    img[7]  = ej(26'h40);
    img[64] = ei(6'h08, 0, 6, 16'hFFFF);
    img[65] = ei(6'h08, 0, 7, 16'd1);
    img[66] = er(6, 7, 8, 6'h2A);
    img[67] = ei(6'h2B, 0, 8, 16'h0084);
    img[68] = ei(6'h05, 1, 1, 16'd2);
    img[69] = ei(6'h05, 1, 6, 16'd1);
    img[70] = 32'hFC00_0000;
    img[71] = ei(6'h23, 0, 1, 16'd2);
  endtask

  task automatic build_c();
    clear_img();
    img[0] = 32'hFC00_0000;
  endtask

  task automatic build_rand();
    int s;
    clear_img();
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 9);
      case (s)
        0, 1, 2: img[i] = ei(6'h08, rr(), rr(), 16'($urandom));
        3, 4, 5: img[i] = er(rr(), rr(), rr(), fn_pick($urandom_range(0, 4)));
        6:       img[i] = ei(6'h23, 0, rr(), 16'(32'h200 + 4 * $urandom_range(0, 63)));
        7:       img[i] = ei(6'h2B, 0, rr(), 16'(32'h200 + 4 * $urandom_range(0, 63)));
        8:       img[i] = ei($urandom_range(0, 1) ? 6'h04 : 6'h05, rr(), rr(), 16'($urandom_range(0, 3)));
        default: img[i] = ej(26'(i + 1 + $urandom_range(0, 2)));
      endcase
    end
    for (int i = 1; i < 32; i++) img[39 + i] = ei(6'h2B, 0, i, 16'(32'h300 + 4 * i));
    s = $urandom_range(0, 3);
    img[71] = s == 0 ? 32'hFC00_0000 : s == 1 ? er(1, 2, 3, 6'h21) :
              s == 2 ? ei(6'h23, 0, 1, 16'h0202) : ei(6'h2B, 0, 1, 16'h0201);
  endtask

  // mode 0: no wait states, 1: three per access, 2: random 0..3
  task automatic run_test(input int mode, input bit abort);
    int n;
    reset = 0;
    @(negedge clock);
    for (int i = 0; i < 1024; i++) begin mem[i] = img[i]; rmem[i] = img[i]; end
    for (int i = 0; i < 4096; i++) wq[i] = mode == 0 ? 0 : mode == 1 ? 3 : $urandom_range(0, 3);
    exp_q.delete();
    ridx = 0;
    run_iss();
    #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", pc_dbg, 0);
    @(negedge clock);
    reset = 1;
    n = 0;
    if (abort) begin
      do begin @(negedge clock); #2; n++; end while (!(mem_req && mem_we && !mem_ready) && n < 500);
      if (n >= 500) begin
        checks++;
        errors++;
        $display("FAIL abort_wait: store never stalled within %0d cycles, expected a stalled store", n);
      end
      #1 reset = 0;
      #1;
      chk("abort_req", 32'(mem_req), 0);
      chk("abort_pc", pc_dbg, 0);
      chk("abort_halted", 32'(halted), 0);
      return;
    end
    do begin @(negedge clock); #2; n++; end while (!halted && n < 3000);
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout: halted=%b after %0d cycles, expected halt at cycle %0d", halted, n, exp_halt);
    end else begin
      chk("halt_cycle", cyc, exp_halt);
      chk("halt_pc", pc_dbg, exp_pc);
      chk("drained", exp_q.size(), 0);
      repeat (3) begin
        @(negedge clock);
        #2;
        chk("halt_req", 32'(mem_req), 0);
        chk("halt_sticky", 32'(halted), 1);
        chk("halt_pc_frozen", pc_dbg, exp_pc);
      end
    end
  endtask

  initial begin
    build_a();
    run_test(0, 0);
    run_test(1, 0);
    build_b();
    run_test(0, 0);
    run_test(2, 0);
    build_c();
    run_test(0, 0);
    build_a();
    run_test(1, 1);
    run_test(1, 0);
    for (int i = 0; i < 4; i++) begin
      build_rand();
      run_test(2, 0);
      run_test(0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
